edge_line_scheduler: RTL

- Time-multiplexes one shared edge_function datapath across a table of NUM_LINES wireframe lines (12 cube edges by default).
- For each accepted pixel it issues every table entry to the edge unit on consecutive cycles, then OR-accumulates the returned pixel_set/pixel_set2 flags over enabled lines.
- Sits between the pixel-coordinate generator and the colour/output stage.
- The line table and threshold are loaded by the frame/transform logic between pixels.

---
 rtl/edge_line_scheduler.sv | 132 +++++++++++++
 1 files changed

// File: rtl/edge_line_scheduler.sv
// Shares one edge unit across a table of wireframe lines: each accepted pixel is tested
// against every entry on consecutive cycles and the per-line flags are OR-reduced.
module edge_line_scheduler #(
    parameter int unsigned NUM_LINES   = 12,
    parameter int unsigned LINE_BITS   = 10,
    parameter int unsigned THRESH_BITS = 8,
    parameter int unsigned EDGE_LAT    = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cfg_we_i,
    input  logic [$clog2(NUM_LINES)-1:0] cfg_idx_i,
    input  logic [4*LINE_BITS-1:0]       cfg_line_i,
    input  logic                         cfg_en_i,
    input  logic                         cfg_thresh_we_i,
    input  logic [THRESH_BITS-1:0]       cfg_thresh_i,
    output logic                         cfg_ready_o,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [LINE_BITS-1:0]         in_x_i,
    input  logic [LINE_BITS-1:0]         in_y_i,
    output logic [4*LINE_BITS-1:0]       edge_line_o,
    output logic [THRESH_BITS-1:0]       edge_thresh_o,
    output logic [LINE_BITS-1:0]         edge_x_o,
    output logic [LINE_BITS-1:0]         edge_y_o,
    input  logic                         edge_set_i,
    input  logic                         edge_set2_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic                         out_set_o,
    output logic                         out_set2_o
);
    localparam int unsigned         IDX_BITS = $clog2(NUM_LINES);
    localparam int unsigned         LINE_W   = 4 * LINE_BITS;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_LINES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [IDX_BITS-1:0]     idx_q;
    logic [LINE_W-1:0]       line_tbl [NUM_LINES];
    logic [NUM_LINES-1:0]    en_tbl;
    logic [THRESH_BITS-1:0]  thresh_q;
    logic [LINE_BITS-1:0]    x_q, y_q;
    logic [EDGE_LAT-1:0]     pipe_iss_q, pipe_en_q;
    logic                    acc_set_q, acc_set2_q, out_valid_q;
    logic                    in_hs, out_hs, issue_c, cfg_wr_ok, capture;

    assign in_ready_o    = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
    assign cfg_ready_o   = (state_q == IDLE);
    assign in_hs         = in_valid_i && in_ready_o;
    assign out_hs        = out_valid_o && out_ready_i;
    assign cfg_wr_ok     = cfg_we_i && cfg_ready_o && (32'(cfg_idx_i) < NUM_LINES);
    assign capture       = pipe_iss_q[EDGE_LAT-1] && pipe_en_q[EDGE_LAT-1];

    assign edge_line_o   = line_tbl[idx_q];
    assign edge_thresh_o = thresh_q;
    assign edge_x_o      = x_q;
    assign edge_y_o      = y_q;
    assign out_valid_o   = out_valid_q;
    assign out_set_o     = acc_set_q;
    assign out_set2_o    = acc_set2_q;

    // Next-state; DRAIN ends once the shift about to happen leaves the issue pipe empty
    always_comb begin
        state_d = state_q;
        issue_c = 1'b0;
        unique case (state_q)
            IDLE:  if (in_hs) state_d = ISSUE;
            ISSUE: begin
                issue_c = 1'b1;
                if (idx_q == LAST_IDX) state_d = DRAIN;
            end
            DRAIN: if (EDGE_LAT'(pipe_iss_q << 1) == '0) state_d = DONE;
            DONE: begin
                if (in_hs)       state_d = ISSUE;
                else if (out_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pipe_iss_q  <= '0;
            pipe_en_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d == DONE);
            pipe_iss_q  <= EDGE_LAT'({pipe_iss_q, issue_c});
            pipe_en_q   <= EDGE_LAT'({pipe_en_q, issue_c && en_tbl[idx_q]});
            if (issue_c) idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
    end

    // Line table and threshold, writable only while idle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_LINES; i++) line_tbl[i] <= '0;
            en_tbl   <= '0;
            thresh_q <= '0;
        end else begin
            if (cfg_wr_ok) begin
                line_tbl[cfg_idx_i] <= cfg_line_i;
                en_tbl[cfg_idx_i]   <= cfg_en_i;
            end
            if (cfg_thresh_we_i && cfg_ready_o) thresh_q <= cfg_thresh_i;
        end
    end

    // Pixel latch and flag accumulators; cleared on every accepted pixel
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q        <= '0;
            y_q        <= '0;
            acc_set_q  <= 1'b0;
            acc_set2_q <= 1'b0;
        end else if (in_hs) begin
            x_q        <= in_x_i;
            y_q        <= in_y_i;
            acc_set_q  <= 1'b0;
            acc_set2_q <= 1'b0;
        end else if (capture) begin
            acc_set_q  <= acc_set_q | edge_set_i;
            acc_set2_q <= acc_set2_q | edge_set2_i;
        end
    end

endmodule
